// File: rtl/operand_b_select_stage_pkg.sv
// Shared mode encoding for the channel-B operand selector and its decoder.
package operand_b_select_stage_pkg;

  localparam int MODE_WIDTH = 2;

  localparam logic [MODE_WIDTH-1:0] MODE_PASS_B   = 2'd0;
  localparam logic [MODE_WIDTH-1:0] MODE_ZERO_EXT = 2'd1;
  localparam logic [MODE_WIDTH-1:0] MODE_SIGN_EXT = 2'd2;
  localparam logic [MODE_WIDTH-1:0] MODE_SCALED   = 2'd3;

endpackage

// File: rtl/operand_b_select_stage_skid_register.sv
// Two-entry valid/ready skid buffer; in_ready is purely registered so there is
// no combinational path from out_ready back to the upstream stage.
module skid_register #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         ready_q;
  logic         accept;
  logic         main_free;

  assign in_ready  = ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

  assign accept    = in_valid & ready_q;
  assign main_free = ~main_valid_q | out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        if (accept) begin
          skid_data_d = in_data;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        // Data is left untouched so the outputs hold their last value.
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ~skid_valid_d;
    end
  end

endmodule

// File: rtl/operand_b_select_stage.sv
// Channel-B operand selector: picks register data or an extended/scaled offset
// and registers it, with its tag and source flag, behind a skid buffer.
module operand_b_select_stage
  import operand_b_select_stage_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 12,
  parameter int SCALE_SHIFT  = 2,
  parameter int TAG_WIDTH    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MODE_WIDTH-1:0]   mode,
  input  logic [DATA_WIDTH-1:0]   input_channel_B,
  input  logic [OFFSET_WIDTH-1:0] Offset,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   updated_channel_B,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    out_is_offset
);

  localparam int W = DATA_WIDTH + TAG_WIDTH + 1;

  logic [DATA_WIDTH-1:0] zero_ext;
  logic [DATA_WIDTH-1:0] sign_ext;
  logic [DATA_WIDTH-1:0] operand;
  logic [W-1:0]          pack_in;
  logic [W-1:0]          pack_out;

  assign zero_ext = {{(DATA_WIDTH-OFFSET_WIDTH){1'b0}}, Offset};
  assign sign_ext = {{(DATA_WIDTH-OFFSET_WIDTH){Offset[OFFSET_WIDTH-1]}}, Offset};

  always_comb begin
    operand = input_channel_B;
    case (mode)
      MODE_PASS_B:   operand = input_channel_B;
      MODE_ZERO_EXT: operand = zero_ext;
      MODE_SIGN_EXT: operand = sign_ext;
      MODE_SCALED:   operand = zero_ext << SCALE_SHIFT;
      default:       operand = input_channel_B;
    endcase
  end

  assign pack_in = {(mode != MODE_PASS_B), in_tag, operand};

  skid_register #(
    .W(W)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (pack_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (pack_out)
  );

  assign updated_channel_B = pack_out[DATA_WIDTH-1:0];
  assign out_tag           = pack_out[DATA_WIDTH +: TAG_WIDTH];
  assign out_is_offset     = pack_out[W-1];

endmodule

// File: tb/tb_operand_b_select_stage.sv
// Directed bench for operand_b_select_stage: reset, modes, streaming, stall and
// async reset on the default instance, plus a narrow-offset instance for truncation.
module tb_operand_b_select_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [31:0] chb;
  logic [11:0] offset;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data;
  logic [3:0]  out_tag;
  logic        is_off;

  logic        n_in_valid;
  logic        n_in_ready;
  logic [1:0]  n_mode;
  logic [7:0]  n_offset;
  logic        n_out_valid;
  logic [31:0] n_data;
  logic [3:0]  n_out_tag;
  logic        n_is_off;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_data [4];
  logic        exp_flag [4];

  always #5 clock = ~clock;

  operand_b_select_stage u_dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .mode             (mode),
    .input_channel_B  (chb),
    .Offset           (offset),
    .in_tag           (in_tag),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .updated_channel_B(data),
    .out_tag          (out_tag),
    .out_is_offset    (is_off)
  );

  operand_b_select_stage #(
    .DATA_WIDTH  (32),
    .OFFSET_WIDTH(8),
    .SCALE_SHIFT (31),
    .TAG_WIDTH   (4)
  ) u_narrow (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (n_in_valid),
    .in_ready         (n_in_ready),
    .mode             (n_mode),
    .input_channel_B  (32'h1234_5678),
    .Offset           (n_offset),
    .in_tag           (4'h9),
    .out_valid        (n_out_valid),
    .out_ready        (1'b1),
    .updated_channel_B(n_data),
    .out_tag          (n_out_tag),
    .out_is_offset    (n_is_off)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    exp_data[0] = 32'hDEADBEEF; exp_flag[0] = 1'b0;
    exp_data[1] = 32'h00000800; exp_flag[1] = 1'b1;
    exp_data[2] = 32'hFFFFF800; exp_flag[2] = 1'b1;
    exp_data[3] = 32'h00002000; exp_flag[3] = 1'b1;

    reset      = 1'b0;
    in_valid   = 1'b1;
    mode       = 2'd0;
    chb        = 32'hDEADBEEF;
    offset     = 12'h800;
    in_tag     = 4'd0;
    out_ready  = 1'b0;
    n_in_valid = 1'b0;
    n_mode     = 2'd0;
    n_offset   = 8'h00;

    // Reset held with in_valid asserted
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_tag", {28'd0, out_tag}, 32'd0);
    check("rst_flag", {31'd0, is_off}, 32'd0);
    tick();
    check("rst_in_ready_edge", {31'd0, in_ready}, 32'd0);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("release_in_ready_pre_edge", {31'd0, in_ready}, 32'd0);
    tick();
    check("release_in_ready_post_edge", {31'd0, in_ready}, 32'd1);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    check("narrow_in_ready", {31'd0, n_in_ready}, 32'd1);

    // Each mode, one cycle after accept
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      in_valid = 1'b1;
      mode     = 2'(m);
      in_tag   = 4'(m);
      tick();
      check("mode_valid", {31'd0, out_valid}, 32'd1);
      check("mode_data", data, exp_data[m]);
      check("mode_flag", {31'd0, is_off}, {31'd0, exp_flag[m]});
      check("mode_tag", {28'd0, out_tag}, m);
      in_valid = 1'b0;
    end
    tick();
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_hold_data", data, 32'h00002000);
    check("idle_hold_tag", {28'd0, out_tag}, 32'd3);

    // Back-to-back stream of 8 tagged transfers
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      mode     = 2'd1;
      offset   = 12'(i * 16 + 1);
      in_tag   = 4'(i);
      tick();
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_tag", {28'd0, out_tag}, i);
      check("stream_data", data, i * 16 + 1);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", {31'd0, out_valid}, 32'd0);

    // Stall with three offered transfers
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode      = 2'd0;
    chb       = 32'hAAAA0001;
    in_tag    = 4'd1;
    tick();
    check("stall_a_valid", {31'd0, out_valid}, 32'd1);
    check("stall_a_tag", {28'd0, out_tag}, 32'd1);
    check("stall_a_in_ready", {31'd0, in_ready}, 32'd1);
    chb    = 32'hBBBB0002;
    in_tag = 4'd2;
    tick();
    check("stall_b_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_b_hold_tag", {28'd0, out_tag}, 32'd1);
    check("stall_b_hold_data", data, 32'hAAAA0001);
    chb    = 32'hCCCC0003;
    in_tag = 4'd3;
    tick();
    check("stall_c_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_c_hold_data", data, 32'hAAAA0001);
    check("stall_c_hold_tag", {28'd0, out_tag}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("drain_b_tag", {28'd0, out_tag}, 32'd2);
    check("drain_b_data", data, 32'hBBBB0002);
    check("drain_b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("drain_c_tag", {28'd0, out_tag}, 32'd3);
    check("drain_c_data", data, 32'hCCCC0003);
    in_valid = 1'b0;
    tick();
    check("drain_end_valid", {31'd0, out_valid}, 32'd0);

    // Narrow offset: truncation on large scale, and sign extension
    n_in_valid = 1'b1;
    n_mode     = 2'd3;
    n_offset   = 8'hFF;
    tick();
    check("narrow_scaled_valid", {31'd0, n_out_valid}, 32'd1);
    check("narrow_scaled_data", n_data, 32'h80000000);
    check("narrow_scaled_flag", {31'd0, n_is_off}, 32'd1);
    n_mode   = 2'd2;
    n_offset = 8'h80;
    tick();
    check("narrow_sign_data", n_data, 32'hFFFFFF80);
    check("narrow_tag", {28'd0, n_out_tag}, 32'd9);
    n_in_valid = 1'b0;
    tick();

    // Async reset mid-stall with skid full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode      = 2'd1;
    offset    = 12'h123;
    in_tag    = 4'd5;
    tick();
    offset = 12'h456;
    in_tag = 4'd6;
    tick();
    check("pre_reset_skid_full", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_data", data, 32'd0);
    check("async_tag", {28'd0, out_tag}, 32'd0);
    check("async_flag", {31'd0, is_off}, 32'd0);
    check("async_in_ready", {31'd0, in_ready}, 32'd0);
    #2;
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_reset_no_stale", {31'd0, out_valid}, 32'd0);
    tick();
    check("post_reset_no_stale_2", {31'd0, out_valid}, 32'd0);
    check("post_reset_data", data, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_b_select_stage.md
Name: operand_b_select_stage

Overview:
Pipelined successor to the ALU channel-B operand selector. It forms operand B from either the register-file channel B or an instruction offset. The offset can be zero-extended, sign-extended, or zero-extended and scaled. The result is registered behind a valid/ready skid buffer, so decode→execute back-pressure never drops or duplicates an operand. It sits between the decode/register-read stage and the ALU input.

Parameters:
DATA_WIDTH, 32, width of channel B and the output operand
OFFSET_WIDTH, 12, width of the immediate offset field; must satisfy 1 <= OFFSET_WIDTH < DATA_WIDTH
SCALE_SHIFT, 2, left-shift applied in mode SCALED; must satisfy 0 <= SCALE_SHIFT < DATA_WIDTH
TAG_WIDTH, 4, width of the sideband tag (destination register index) carried alongside the operand

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  upstream presents a transfer
in_ready  output  1  stage can accept a transfer
mode  input  2  operand source/extension select; qualified by in_valid
input_channel_B  input  DATA_WIDTH  register-file channel B
Offset  input  OFFSET_WIDTH  instruction offset field
in_tag  input  TAG_WIDTH  sideband tag, passed through unchanged
out_valid  output  1  updated_channel_B and out_tag are valid
out_ready  input  1  downstream accepts the transfer
updated_channel_B  output  DATA_WIDTH  selected and extended operand
out_tag  output  TAG_WIDTH  tag of the operand on the output
out_is_offset  output  1  1 when the output operand came from Offset (mode != PASS_B)

Behaviour:
- Mode encoding:
  - 0 PASS_B = input_channel_B
  - 1 ZERO_EXT = {zeros, Offset}
  - 2 SIGN_EXT = Offset replicated from bit OFFSET_WIDTH-1
  - 3 SCALED = ZERO_EXT value << SCALE_SHIFT, truncated to DATA_WIDTH; shifted-in bits are 0.
- Operand formation is combinational on the inputs. The result, in_tag and the offset flag are captured at acceptance.
- Transfers:
  - Accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- State:
  - main register (valid, data, tag, flag) drives the outputs;
  - skid register (valid, data, tag, flag).
- in_ready = ~skid_valid, derived from a register with no combinational path from out_ready. It is forced to 0 while reset is asserted.
- Each rising edge, with main "free" = ~main_valid | out_ready:
  - main free, skid valid: main <- skid; skid <- accepted input if any, else skid_valid <- 0.
  - main free, skid empty: main <- accepted input, else main_valid <- 0.
  - main busy (out_valid & ~out_ready): accepted input -> skid. Main holds; outputs must not change while stalled.
- Latency: 1 cycle from accept to out_valid with no stall. Throughput is 1 transfer per cycle when out_ready is held at 1.
- Ordering: strict FIFO, 2 entries maximum. Full (skid valid) gives in_ready=0. Empty gives out_valid=0.
- Simultaneous accept and output transfer with skid empty: main is replaced, no bubble.
- Simultaneous transfers with skid valid: skid moves to main and the new input is not accepted, because in_ready=0.
- While out_valid=0, updated_channel_B, out_tag and out_is_offset hold their last values; they are 0 after reset.
- Reset (asynchronous, any time including mid-stall): out_valid=0, skid_valid=0, updated_channel_B=0, out_tag=0, out_is_offset=0. In-flight operands are discarded. in_ready rises to 1 on the first clock edge after release.
- Mode is not checked when in_valid=0. All 4 encodings are legal; there is no error state.

Decomposition:
- Shared package/header: mode localparams MODE_PASS_B=0, MODE_ZERO_EXT=1, MODE_SIGN_EXT=2, MODE_SCALED=3, plus MODE_WIDTH=2. The decoder uses the same constants.
- Sub-module skid_register: generic width W, same handshake and reset. The parent instantiates it with W = DATA_WIDTH+TAG_WIDTH+1; the parent keeps only the combinational operand former.

Test Plan:
- Reset held 0 with in_valid=1 -> in_ready=0, out_valid=0, outputs 0; after release in_ready=1 next edge.
- Defaults; out_ready=1; modes 0..3 with input_channel_B=0xDEADBEEF, Offset=0x800 -> 0xDEADBEEF, 0x00000800, 0xFFFFF800, 0x00002000; out_is_offset 0,1,1,1; each 1 cycle after accept.
- Back-to-back stream of 8 tagged transfers, out_ready=1 -> 8 outputs in consecutive cycles, tags 0..7 in order, no bubbles.
- out_ready=0 with 3 offered transfers -> 2 accepted, in_ready=0 after the second, output stable. Raise out_ready -> the 2 held operands drain in order, then the third is accepted.
- Reset asserted asynchronously mid-clock while skid full -> outputs clear immediately without a clock edge; no stale operand appears after release.
- OFFSET_WIDTH=8, SCALE_SHIFT=31, Offset=0xFF, mode SCALED -> 0x80000000, confirming truncation.
